// File: rtl/cp_remove_framer.sv
// Cyclic-prefix removal and symbol framing between preamble removal and the FFT.
// Buffers each symbol's useful samples in a ping-pong RAM and streams them out.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sync_clear   1-cycle pulse: abandon the packet, return to symbol position 0
//   in_valid     in_real/in_imag carry a sample this cycle
//   in_real      sample real part
//   in_imag      sample imag part
//   out_ready    FFT accepts out_* this cycle
//   out_valid    out_* hold a valid useful sample
//   out_real     useful sample real part
//   out_imag     useful sample imag part
//   out_sop      first useful sample of a symbol
//   out_eop      last useful sample of a symbol
//   out_sym_idx  symbol index, 0 after reset/clear, wraps 255->0
//   overflow     sticky: a symbol was dropped because no bank was free
module cp_remove_framer #(
    parameter int DATA_W = 16,
    parameter int N_FFT  = 64,
    parameter int N_CP   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_sop,
    output logic              out_eop,
    output logic [7:0]        out_sym_idx,
    output logic              overflow
);

    localparam int SYM_LEN = N_CP + N_FFT;
    localparam int POS_W   = $clog2(SYM_LEN);
    localparam int ADDR_W  = $clog2(N_FFT);

    localparam logic [POS_W-1:0]  POS_CP    = POS_W'(N_CP);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SYM_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_FFT - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

    // Ping-pong sample RAM: bank is the address MSB.
    logic [2*DATA_W-1:0] mem [2*N_FFT];

    // Write side state
    logic [POS_W-1:0] pos;
    logic             wr_bank;
    logic [7:0]       wr_sym;
    logic             sym_drop;

    // Bank bookkeeping
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_d;
    logic [7:0]       bank_tag [2];

    // Read side state
    rd_state_t        state;
    rd_state_t        state_d;
    logic             rd_bank;
    logic             rd_bank_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_d;
    logic             valid_d;
    logic             load_en;
    logic             load_bank;
    logic [ADDR_W-1:0] load_addr;
    logic             free_en;

    // Write side decode
    logic             at_cp;
    logic             at_last;
    logic             useful;
    logic             bank_busy;
    logic             drop_now;
    logic             wr_en;
    logic             set_en;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        at_cp     = in_valid && (pos == POS_CP);
        at_last   = in_valid && (pos == POS_LAST);
        useful    = in_valid && (pos >= POS_CP);
        // A bank released by the reader this very cycle counts as free.
        bank_busy = bank_full[wr_bank] &&
                    !(free_en && (rd_bank == wr_bank));
        // The keep/drop decision is taken at the first useful sample
        // and then held for the rest of the symbol.
        drop_now  = at_cp ? bank_busy : sym_drop;
        wr_en     = useful && !drop_now && !sync_clear;
        set_en    = at_last && !drop_now && !sync_clear;
        wr_addr   = ADDR_W'(pos - POS_CP);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= {in_real, in_imag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos      <= '0;
            wr_bank  <= 1'b0;
            wr_sym   <= 8'd0;
            sym_drop <= 1'b0;
            overflow <= 1'b0;
        end else if (sync_clear) begin
            pos      <= '0;
            wr_bank  <= 1'b0;
            wr_sym   <= 8'd0;
            sym_drop <= 1'b0;
        end else if (in_valid) begin
            if (at_cp) begin
                sym_drop <= bank_busy;
                if (bank_busy) begin
                    overflow <= 1'b1;
                end
            end
            if (pos == POS_LAST) begin
                pos    <= '0;
                wr_sym <= wr_sym + 8'd1;
                // A dropped symbol leaves the write bank in place so the
                // next symbol retries the same bank.
                if (!drop_now) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                pos <= pos + 1'b1;
            end
        end
    end

    always_comb begin
        bank_full_d = bank_full;
        if (free_en) begin
            bank_full_d[rd_bank] = 1'b0;
        end
        if (set_en) begin
            bank_full_d[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full   <= 2'b00;
            bank_tag[0] <= 8'd0;
            bank_tag[1] <= 8'd0;
        end else if (sync_clear) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_d;
            if (set_en) begin
                bank_tag[wr_bank] <= wr_sym;
            end
        end
    end

    // Read FSM. Banks fill in alternating order and are drained in the
    // same order, so rd_bank always names the older full bank.
    always_comb begin
        state_d   = state;
        rd_bank_d = rd_bank;
        rd_addr_d = rd_addr;
        valid_d   = out_valid;
        load_en   = 1'b0;
        load_bank = rd_bank;
        load_addr = rd_addr;
        free_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    load_en   = 1'b1;
                    load_addr = '0;
                    rd_addr_d = ADDR_W'(1);
                    valid_d   = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_eop) begin
                        free_en   = 1'b1;
                        rd_bank_d = ~rd_bank;
                        if (bank_full[~rd_bank]) begin
                            load_en   = 1'b1;
                            load_bank = ~rd_bank;
                            load_addr = '0;
                            rd_addr_d = ADDR_W'(1);
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        load_en   = 1'b1;
                        rd_addr_d = rd_addr + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The RAM read register doubles as the output register, giving
    // two-cycle latency from the last written sample to out_sop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_real    <= '0;
            out_imag    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_sym_idx <= 8'd0;
        end else if (sync_clear) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            state     <= state_d;
            rd_bank   <= rd_bank_d;
            rd_addr   <= rd_addr_d;
            out_valid <= valid_d;
            if (load_en) begin
                {out_real, out_imag} <= mem[{load_bank, load_addr}];
                out_sop     <= (load_addr == '0);
                out_eop     <= (load_addr == ADDR_LAST);
                out_sym_idx <= bank_tag[load_bank];
            end
        end
    end

endmodule
